// File: rtl/risc_dof_operand_stage.sv
// rtl/risc_dof_operand_stage.sv - decode/operand-fetch stage: operand select, hazard stall, DOF/EX register
// Optional feature: DOF_FWD_EN (EX/WB forwarding; undefined -> stall on any EX/WB source hazard)
module risc_dof_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        dof_valid,
  output logic        dof_ready,
  input  logic [4:0]  dof_aa,
  input  logic [4:0]  dof_ba,
  input  logic [4:0]  dof_da,
  input  logic        dof_rw,
  input  logic        dof_md,
  input  logic        dof_ma,
  input  logic        dof_mb,
  input  logic        dof_cs,
  input  logic [14:0] dof_imm,
  input  logic [31:0] dof_pc,
  input  logic        flush,
  output logic [4:0]  rf_aa,
  output logic [4:0]  rf_ba,
  input  logic [31:0] rf_bus_a,
  input  logic [31:0] rf_bus_b,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  wb_da,
  input  logic        wb_rw,
  input  logic [31:0] wb_bus_d,
  output logic        ex_valid,
  output logic        ex_rw,
  output logic        ex_md,
  output logic [4:0]  ex_da,
  output logic [31:0] ex_bus_a,
  output logic [31:0] ex_bus_b,
  output logic [15:0] stall_count
);

  logic        use_a;
  logic        use_b;
  logic        ex_wr;
  logic        ex_hit_a;
  logic        ex_hit_b;
  logic        wb_hit_a;
  logic        wb_hit_b;
  logic        hazard;
  logic        stall;
  logic        capture;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic [31:0] imm_ext;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  assign rf_aa = dof_aa;
  assign rf_ba = dof_ba;

  // R0 is hardwired zero, so it never participates in a hazard
  assign use_a = ~dof_ma & (dof_aa != 5'd0);
  assign use_b = ~dof_mb & (dof_ba != 5'd0);

  assign ex_wr    = ex_valid & ex_rw;
  assign ex_hit_a = use_a & ex_wr & (ex_da == dof_aa);
  assign ex_hit_b = use_b & ex_wr & (ex_da == dof_ba);
  assign wb_hit_a = use_a & wb_rw & (wb_da == dof_aa);
  assign wb_hit_b = use_b & wb_rw & (wb_da == dof_ba);

`ifdef DOF_FWD_EN
  // Only a load in EX cannot be forwarded: its data is not available yet
  assign hazard = dof_valid & ex_md & (ex_hit_a | ex_hit_b);

  always_comb begin
    opnd_a = rf_bus_a;
    if (ex_hit_a & ~ex_md)
      opnd_a = ex_alu_result;
    else if (wb_hit_a)
      opnd_a = wb_bus_d;
  end

  always_comb begin
    opnd_b = rf_bus_b;
    if (ex_hit_b & ~ex_md)
      opnd_b = ex_alu_result;
    else if (wb_hit_b)
      opnd_b = wb_bus_d;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_alu_result, wb_bus_d};

  // Without forwarding, wait until the producer has left WB
  assign hazard = dof_valid & (ex_hit_a | ex_hit_b | wb_hit_a | wb_hit_b);
  assign opnd_a = rf_bus_a;
  assign opnd_b = rf_bus_b;
`endif

  assign imm_ext = dof_cs ? {{17{dof_imm[14]}}, dof_imm} : {17'b0, dof_imm};
  assign sel_a   = dof_ma ? dof_pc : opnd_a;
  assign sel_b   = dof_mb ? imm_ext : opnd_b;

  // Flush kills the instruction anyway, so it overrides any stall
  assign stall     = hazard & ~flush;
  assign dof_ready = ~stall;
  assign capture   = dof_valid & ~flush & ~hazard;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rw       <= 1'b0;
      ex_md       <= 1'b0;
      ex_da       <= 5'd0;
      ex_bus_a    <= 32'd0;
      ex_bus_b    <= 32'd0;
      stall_count <= 16'd0;
    end else begin
      ex_valid <= capture;
      ex_rw    <= capture & dof_rw;
      ex_md    <= capture & dof_md;
      ex_da    <= capture ? dof_da : 5'd0;
      if (capture) begin
        ex_bus_a <= sel_a;
        ex_bus_b <= sel_b;
      end
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/risc_dof_operand_stage.md
# risc_dof_operand_stage

Decode/operand-fetch (DOF) stage of the 5-stage RISC pipeline; drives the register-file read addresses and consumes the two combinational read buses. Resolves operands through EX/WB forwarding, immediate/PC muxing and load-use stall detection. Produces the registered DOF/EX pipeline register feeding the ALU.

## Interface
Parameters:
- none

Ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dof_valid  in  1  decoded instruction present
- dof_ready  out  1  stage accepts instruction this cycle (combinational)
- dof_aa, dof_ba, dof_da  in  5  source A, source B, destination register
- dof_rw  in  1  instruction writes dof_da
- dof_md  in  1  instruction is a load (result from memory)
- dof_ma  in  1  1: bus A = dof_pc instead of register A
- dof_mb  in  1  1: bus B = immediate instead of register B
- dof_cs  in  1  1: sign-extend immediate, 0: zero-extend
- dof_imm  in  15  immediate field
- dof_pc  in  32  PC of the instruction
- flush  in  1  branch taken; kill DOF contents
- rf_aa, rf_ba  out  5  register-file read addresses (= dof_aa, dof_ba, combinational)
- rf_bus_a, rf_bus_b  in  32  register-file read data (combinational)
- ex_alu_result  in  32  ALU result of instruction currently in EX
- wb_da  in  5; wb_rw  in  1; wb_bus_d  in  32  write-back port, same signals as register-file write
- ex_valid, ex_rw, ex_md  out  1  registered control to EX
- ex_da  out  5  registered destination
- ex_bus_a, ex_bus_b  out  32  registered operands
- stall_count  out  16  saturating count of stall cycles

## Operation
- Source A used iff dof_ma=0; source B used iff dof_mb=0. Register 0 reads 0 and never matches a hazard.
- Operand select per used source (priority high to low): EX match (ex_valid & ex_rw & ex_da==src & ex_md=0) -> ex_alu_result; WB match (wb_rw & wb_da==src) -> wb_bus_d; else rf_bus. WB forwarding is mandatory because the register file writes on the same edge.
- Immediate: {17{dof_imm[14]}} or 17'b0 concatenated with dof_imm per dof_cs.
- Load-use stall: dof_valid & used source matches ex_da with ex_valid & ex_rw & ex_md=1. Then dof_ready=0; pipeline register loads a bubble (ex_valid=ex_rw=ex_md=0, ex_da=0, buses hold); DOF inputs must be held by upstream.
- Flush: dof_ready=1, register loads a bubble; flush dominates stall; no stall counted.
- dof_valid=0: bubble loaded, dof_ready=1.
- Otherwise instruction captured: ex_valid=1, ex_rw/ex_md/ex_da copied, ex_bus_a/b = selected operands.
- stall_count increments once per stall cycle, saturates at 16'hFFFF.

## Timing
- One-cycle latency DOF -> EX register; dof_ready and rf_aa/rf_ba combinational from current inputs and EX register.
- Load-use costs exactly one bubble; next cycle load is in WB and operand comes from wb_bus_d.
- Reset (sync): ex_valid=ex_rw=ex_md=0, ex_da=0, ex_bus_a=ex_bus_b=0, stall_count=0; reset mid-stall discards held instruction state (upstream re-issues).

## Configuration
- DOF_FWD_EN defined: forwarding as above.
- DOF_FWD_EN undefined: no EX/WB forwarding muxes; operand always rf_bus; stall on any used-source match against EX (ex_valid & ex_rw) or WB (wb_rw); stall_count counts these stalls too. Load-use case subsumed.

## Test plan
- Reset then dof_aa=3,dof_ba=4, rf buses 30/40 -> next cycle ex_bus_a=30, ex_bus_b=40, ex_valid=1; stall_count=0.
- ADD R5 then dependent SUB using R5, ex_alu_result=0x55 -> SUB captures ex_bus_a=0x55, no stall; without DOF_FWD_EN, 2 stall cycles, stall_count=2.
- Load to R7 then use R7 -> one cycle dof_ready=0, bubble (ex_valid=0), then ex_bus_a=wb_bus_d=0xDEAD; stall_count=1.
- wb_rw=1,wb_da=9,wb_bus_d=0x99, rf_bus_a=0x11, dof_aa=9 -> ex_bus_a=0x99; dof_aa=0 with wb_da=0 -> rf value used, no stall.
- dof_mb=1, dof_cs=1, dof_imm=15'h7FFF -> ex_bus_b=32'hFFFFFFFF; dof_cs=0 -> 32'h00007FFF; dof_ma=1, dof_pc=0x100 -> ex_bus_a=0x100.
- Load-use stall with flush=1 same cycle -> dof_ready=1, bubble, stall_count unchanged; reset asserted during stall -> all outputs zero next edge.
